riscv_trap_unit: RTL and testbench
==================================

RISCV_TRAP_UNIT -- requirements
Module: riscv_trap_unit

Interface
REQ-001 SHALL have parameter XLEN, default 64, giving the data/address width.
REQ-002 SHALL have ports, in this order:
- i_riscv_trap_clk  in  1  sole clock, rising edge.
- i_riscv_trap_rst  in  1  reset; synchronous, active-high.
- i_riscv_trap_valid  in  1  a retiring instruction is presented this cycle.
- i_riscv_trap_inst_addr_misaligned  in  1  from exception unit.
- i_riscv_trap_load_addr_misaligned  in  1  from exception unit.
- i_riscv_trap_store_addr_misaligned  in  1  from exception unit.
- i_riscv_trap_illegal_inst  in  1  decode flagged illegal.
- i_riscv_trap_ecall  in  1  ECALL retiring.
- i_riscv_trap_ebreak  in  1  EBREAK retiring.
- i_riscv_trap_mret  in  1  MRET retiring.
- i_riscv_trap_pc  in  XLEN  PC of the presented instruction.
- i_riscv_trap_icu_result  in  XLEN  computed target/effective address.
- i_riscv_trap_mtvec  in  XLEN  current mtvec CSR.
- i_riscv_trap_mepc  in  XLEN  current mepc CSR.
- o_riscv_trap_csr_we  out  1  one-cycle write strobe for mcause/mtval/mepc/mstatus.
- o_riscv_trap_mcause  out  XLEN  cause value to write.
- o_riscv_trap_mtval  out  XLEN  trap value to write.
- o_riscv_trap_mepc  out  XLEN  exception PC to write.
- o_riscv_trap_mret_commit  out  1  one-cycle strobe: mstatus.MIE<=MPIE, MPIE<=1.
- o_riscv_trap_flush  out  1  kill all younger pipeline stages.
- o_riscv_trap_stall  out  1  hold fetch/decode/execute.
- o_riscv_trap_redirect_valid  out  1  one-cycle PC redirect strobe.
- o_riscv_trap_redirect_pc  out  XLEN  redirect target.

Function
REQ-003 SHALL define "trap" as i_valid high with any of the six exception inputs high, sampled only in IDLE.
REQ-004 SHALL select one cause by fixed priority: illegal (2) > ebreak (3) > ecall (11) > inst misaligned (0) > load misaligned (4) > store misaligned (6); mcause MSB SHALL be 0.
REQ-005 SHALL set mtval: misaligned causes -> i_icu_result; ebreak -> i_pc; illegal, ecall -> 0.
REQ-006 SHALL latch cause, tval, epc (= i_pc) at the detection edge; later input changes SHALL NOT alter them.
REQ-007 SHALL implement states IDLE, TRAP_WR, TRAP_JMP, MRET_JMP.
REQ-008 IDLE->TRAP_WR on trap; IDLE->MRET_JMP on i_valid & i_mret with no trap; else stay IDLE.
REQ-009 TRAP_WR (one cycle): csr_we=1, flush=1, stall=1; next TRAP_JMP.
REQ-010 TRAP_JMP (one cycle): redirect_valid=1, redirect_pc={mtvec[XLEN-1:2],2'b00}, stall=1; next IDLE.
REQ-011 MRET_JMP (one cycle): mret_commit=1, flush=1, redirect_valid=1, redirect_pc={mepc[XLEN-1:1],1'b0}; next IDLE.
REQ-012 Latency: trap detected at edge N -> csr_we during cycle N+1 -> redirect during cycle N+2; mret -> redirect during cycle N+1.
REQ-013 Simultaneous trap and mret SHALL take the trap; mret SHALL be dropped.
REQ-014 Inputs while not IDLE SHALL be ignored; back-to-back traps SHALL be accepted from the first IDLE cycle.
REQ-015 mcause/mtval/mepc outputs SHALL be driven from the latches at all times; they are qualified only by csr_we.
REQ-016 All strobes SHALL be 0 in IDLE; i_valid low SHALL never start a sequence.

Reset
REQ-017 On i_rst high at a rising edge: state<=IDLE, latches<=0, all outputs 0 the following cycle, including mid-sequence; no partial csr_we or redirect SHALL be emitted after reset.

Structure
REQ-018 Cause codes and the state enum SHALL live in the shared package riscv_pkg.
REQ-019 The priority/mtval selection SHALL be a combinational sub-module riscv_trap_prio; FSM and latches stay in riscv_trap_unit.

Verification
REQ-020 Load misaligned: pc=0x1000, icu=0x2003, valid -> N+1 csr_we, mcause=4, mtval=0x2003, mepc=0x1000, flush; N+2 redirect to mtvec 0x8000_0001 -> 0x8000_0000.
REQ-021 Illegal+load misaligned same cycle -> mcause=2, mtval=0.
REQ-022 MRET with mepc=0x4003 -> N+1 mret_commit, flush, redirect_pc=0x4002; no csr_we.
REQ-023 ECALL and MRET together -> mcause=11 sequence only; mret_commit never asserted.
REQ-024 Reset asserted in TRAP_WR -> no redirect on following cycles; outputs 0; new trap accepted after reset releases.
REQ-025 Store misaligned arriving during TRAP_JMP -> ignored; exactly one csr_we/redirect per accepted trap.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V trap definitions: exception cause codes and the trap sequencer states.
package riscv_pkg;

  localparam logic [4:0] CAUSE_INST_MISALIGNED  = 5'd0;
  localparam logic [4:0] CAUSE_ILLEGAL_INST     = 5'd2;
  localparam logic [4:0] CAUSE_BREAKPOINT       = 5'd3;
  localparam logic [4:0] CAUSE_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] CAUSE_STORE_MISALIGNED = 5'd6;
  localparam logic [4:0] CAUSE_ECALL_M          = 5'd11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_TRAP_WR  = 2'd1,
    ST_TRAP_JMP = 2'd2,
    ST_MRET_JMP = 2'd3
  } trap_state_e;

endpackage

// File: rtl/riscv_trap_prio.sv
// Combinational exception arbiter: picks one cause by fixed priority and its mtval.
// Zero latency, no flow control; the caller qualifies o_trap with instruction valid.
module riscv_trap_prio
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_inst_addr_misaligned,
  input  logic            i_load_addr_misaligned,
  input  logic            i_store_addr_misaligned,
  input  logic            i_illegal_inst,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_icu_result,
  output logic            o_trap,
  output logic [XLEN-1:0] o_cause,
  output logic [XLEN-1:0] o_tval
);

  logic [4:0] cause_code;

  always_comb begin
    o_trap     = i_illegal_inst | i_ebreak | i_ecall |
                 i_inst_addr_misaligned | i_load_addr_misaligned | i_store_addr_misaligned;
    cause_code = CAUSE_INST_MISALIGNED;
    o_tval     = '0;
    if (i_illegal_inst) begin
      cause_code = CAUSE_ILLEGAL_INST;
    end else if (i_ebreak) begin
      cause_code = CAUSE_BREAKPOINT;
      o_tval     = i_pc;
    end else if (i_ecall) begin
      cause_code = CAUSE_ECALL_M;
    end else if (i_inst_addr_misaligned) begin
      cause_code = CAUSE_INST_MISALIGNED;
      o_tval     = i_icu_result;
    end else if (i_load_addr_misaligned) begin
      cause_code = CAUSE_LOAD_MISALIGNED;
      o_tval     = i_icu_result;
    end else if (i_store_addr_misaligned) begin
      cause_code = CAUSE_STORE_MISALIGNED;
      o_tval     = i_icu_result;
    end
    // Synchronous exceptions only, so the interrupt bit stays clear.
    o_cause = XLEN'(cause_code);
  end

endmodule

// File: rtl/riscv_trap_unit.sv
// Machine-mode trap/MRET sequencer: trap -> CSR write (N+1) -> redirect (N+2); MRET -> redirect (N+1).
// Inputs are only sampled in IDLE; stall holds the pipeline for the duration of a trap sequence.
module riscv_trap_unit
  import riscv_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            i_riscv_trap_clk,
  input  logic            i_riscv_trap_rst,
  input  logic            i_riscv_trap_valid,
  input  logic            i_riscv_trap_inst_addr_misaligned,
  input  logic            i_riscv_trap_load_addr_misaligned,
  input  logic            i_riscv_trap_store_addr_misaligned,
  input  logic            i_riscv_trap_illegal_inst,
  input  logic            i_riscv_trap_ecall,
  input  logic            i_riscv_trap_ebreak,
  input  logic            i_riscv_trap_mret,
  input  logic [XLEN-1:0] i_riscv_trap_pc,
  input  logic [XLEN-1:0] i_riscv_trap_icu_result,
  input  logic [XLEN-1:0] i_riscv_trap_mtvec,
  input  logic [XLEN-1:0] i_riscv_trap_mepc,
  output logic            o_riscv_trap_csr_we,
  output logic [XLEN-1:0] o_riscv_trap_mcause,
  output logic [XLEN-1:0] o_riscv_trap_mtval,
  output logic [XLEN-1:0] o_riscv_trap_mepc,
  output logic            o_riscv_trap_mret_commit,
  output logic            o_riscv_trap_flush,
  output logic            o_riscv_trap_stall,
  output logic            o_riscv_trap_redirect_valid,
  output logic [XLEN-1:0] o_riscv_trap_redirect_pc
);

  trap_state_e     state_q, state_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mepc_q, mepc_d;

  logic            prio_trap;
  logic [XLEN-1:0] prio_cause;
  logic [XLEN-1:0] prio_tval;

  riscv_trap_prio #(.XLEN(XLEN)) u_prio (
    .i_inst_addr_misaligned  (i_riscv_trap_inst_addr_misaligned),
    .i_load_addr_misaligned  (i_riscv_trap_load_addr_misaligned),
    .i_store_addr_misaligned (i_riscv_trap_store_addr_misaligned),
    .i_illegal_inst          (i_riscv_trap_illegal_inst),
    .i_ecall                 (i_riscv_trap_ecall),
    .i_ebreak                (i_riscv_trap_ebreak),
    .i_pc                    (i_riscv_trap_pc),
    .i_icu_result            (i_riscv_trap_icu_result),
    .o_trap                  (prio_trap),
    .o_cause                 (prio_cause),
    .o_tval                  (prio_tval)
  );

  always_comb begin
    state_d                     = state_q;
    mcause_d                    = mcause_q;
    mtval_d                     = mtval_q;
    mepc_d                      = mepc_q;
    o_riscv_trap_csr_we         = 1'b0;
    o_riscv_trap_mret_commit    = 1'b0;
    o_riscv_trap_flush          = 1'b0;
    o_riscv_trap_stall          = 1'b0;
    o_riscv_trap_redirect_valid = 1'b0;
    o_riscv_trap_redirect_pc    = '0;
    unique case (state_q)
      ST_IDLE: begin
        // A trap outranks an MRET retiring in the same cycle.
        if (i_riscv_trap_valid && prio_trap) begin
          state_d  = ST_TRAP_WR;
          mcause_d = prio_cause;
          mtval_d  = prio_tval;
          mepc_d   = i_riscv_trap_pc;
        end else if (i_riscv_trap_valid && i_riscv_trap_mret) begin
          state_d = ST_MRET_JMP;
        end
      end
      ST_TRAP_WR: begin
        o_riscv_trap_csr_we = 1'b1;
        o_riscv_trap_flush  = 1'b1;
        o_riscv_trap_stall  = 1'b1;
        state_d             = ST_TRAP_JMP;
      end
      ST_TRAP_JMP: begin
        o_riscv_trap_redirect_valid = 1'b1;
        o_riscv_trap_redirect_pc    = i_riscv_trap_mtvec & ~XLEN'(3);
        o_riscv_trap_stall          = 1'b1;
        state_d                     = ST_IDLE;
      end
      ST_MRET_JMP: begin
        o_riscv_trap_mret_commit    = 1'b1;
        o_riscv_trap_flush          = 1'b1;
        o_riscv_trap_redirect_valid = 1'b1;
        o_riscv_trap_redirect_pc    = i_riscv_trap_mepc & ~XLEN'(1);
        state_d                     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_riscv_trap_clk) begin
    if (i_riscv_trap_rst) begin
      state_q  <= ST_IDLE;
      mcause_q <= '0;
      mtval_q  <= '0;
      mepc_q   <= '0;
    end else begin
      state_q  <= state_d;
      mcause_q <= mcause_d;
      mtval_q  <= mtval_d;
      mepc_q   <= mepc_d;
    end
  end

  assign o_riscv_trap_mcause = mcause_q;
  assign o_riscv_trap_mtval  = mtval_q;
  assign o_riscv_trap_mepc   = mepc_q;

endmodule

// File: tb/tb_riscv_trap_unit.sv
// Directed bench for riscv_trap_unit: trap/MRET sequences, priority, reset and overlap cases.
module tb_riscv_trap_unit;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid, inst_mis, load_mis, store_mis, illegal, ecall, ebreak, mret;
  logic [XLEN-1:0] pc, icu, mtvec, mepc_in;
  logic            csr_we, mret_commit, flush, stall, redirect_valid;
  logic [XLEN-1:0] mcause, mtval, mepc_out, redirect_pc;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  riscv_trap_unit #(.XLEN(XLEN)) dut (
    .i_riscv_trap_clk                   (clk),
    .i_riscv_trap_rst                   (rst),
    .i_riscv_trap_valid                 (valid),
    .i_riscv_trap_inst_addr_misaligned  (inst_mis),
    .i_riscv_trap_load_addr_misaligned  (load_mis),
    .i_riscv_trap_store_addr_misaligned (store_mis),
    .i_riscv_trap_illegal_inst          (illegal),
    .i_riscv_trap_ecall                 (ecall),
    .i_riscv_trap_ebreak                (ebreak),
    .i_riscv_trap_mret                  (mret),
    .i_riscv_trap_pc                    (pc),
    .i_riscv_trap_icu_result            (icu),
    .i_riscv_trap_mtvec                 (mtvec),
    .i_riscv_trap_mepc                  (mepc_in),
    .o_riscv_trap_csr_we                (csr_we),
    .o_riscv_trap_mcause                (mcause),
    .o_riscv_trap_mtval                 (mtval),
    .o_riscv_trap_mepc                  (mepc_out),
    .o_riscv_trap_mret_commit           (mret_commit),
    .o_riscv_trap_flush                 (flush),
    .o_riscv_trap_stall                 (stall),
    .o_riscv_trap_redirect_valid        (redirect_valid),
    .o_riscv_trap_redirect_pc           (redirect_pc)
  );

  // Advance past the next rising edge; outputs are stable at the sample point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_flags();
    valid = 0; inst_mis = 0; load_mis = 0; store_mis = 0;
    illegal = 0; ecall = 0; ebreak = 0; mret = 0;
  endtask

  task automatic test_reset();
    rst = 1; clear_flags();
    pc = '0; icu = '0; mtvec = '0; mepc_in = '0;
    tick(); tick();
    rst = 0;
    checks++;
    if ({csr_we, mret_commit, flush, stall, redirect_valid} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes: got %b want 00000", {csr_we, mret_commit, flush, stall, redirect_valid});
    end
    checks++;
    if ({mcause, mtval, mepc_out, redirect_pc} !== '0) begin
      errors++; $display("FAIL reset_data: mcause=%h mtval=%h mepc=%h rpc=%h want all 0", mcause, mtval, mepc_out, redirect_pc);
    end
  endtask

  task automatic test_load_misaligned();
    pc = 64'h1000; icu = 64'h2003; mtvec = 64'h8000_0001;
    valid = 1; load_mis = 1;
    tick();
    clear_flags(); pc = 64'hDEAD; icu = 64'hBEEF;
    checks++;
    if ({csr_we, flush, stall, redirect_valid} !== 4'b1110) begin
      errors++; $display("FAIL lm_wr_strobes: got %b want 1110", {csr_we, flush, stall, redirect_valid});
    end
    checks++;
    if (mcause !== 64'd4 || mtval !== 64'h2003 || mepc_out !== 64'h1000) begin
      errors++; $display("FAIL lm_csr: mcause=%h mtval=%h mepc=%h want 4/2003/1000", mcause, mtval, mepc_out);
    end
    tick();
    checks++;
    if ({csr_we, stall, redirect_valid} !== 3'b011 || redirect_pc !== 64'h8000_0000) begin
      errors++; $display("FAIL lm_jmp: strobes=%b rpc=%h want 011/80000000", {csr_we, stall, redirect_valid}, redirect_pc);
    end
    tick();
    checks++;
    if ({csr_we, flush, stall, redirect_valid, mret_commit} !== 5'b0) begin
      errors++; $display("FAIL lm_idle: got %b want 00000", {csr_we, flush, stall, redirect_valid, mret_commit});
    end
  endtask

  task automatic test_priority();
    // flags = {illegal, ebreak, ecall, inst, load, store}; tsel 0=zero 1=pc 2=icu
    logic [5:0] flags [6] = '{6'b100010, 6'b011000, 6'b001100, 6'b000111, 6'b000011, 6'b000001};
    int         cause [6] = '{2, 3, 11, 0, 4, 6};
    int         tsel  [6] = '{0, 1, 0, 2, 2, 2};
    for (int i = 0; i < 6; i++) begin
      logic [XLEN-1:0] exp_tval;
      pc = 64'h100 + 64'(i * 16); icu = 64'h7001 + 64'(i);
      exp_tval = (tsel[i] == 0) ? 64'h0 : (tsel[i] == 1) ? pc : icu;
      valid = 1;
      {illegal, ebreak, ecall, inst_mis, load_mis, store_mis} = flags[i];
      tick();
      clear_flags();
      checks++;
      if (csr_we !== 1'b1 || mcause !== 64'(cause[i]) || mtval !== exp_tval) begin
        errors++; $display("FAIL prio_%0d: we=%b mcause=%h mtval=%h want 1/%h/%h", i, csr_we, mcause, mtval, 64'(cause[i]), exp_tval);
      end
      tick(); tick();
    end
  endtask

  task automatic test_mret();
    mepc_in = 64'h4003; valid = 1; mret = 1;
    tick();
    clear_flags();
    checks++;
    if ({mret_commit, flush, redirect_valid, csr_we, stall} !== 5'b11100 || redirect_pc !== 64'h4002) begin
      errors++; $display("FAIL mret_jmp: strobes=%b rpc=%h want 11100/4002", {mret_commit, flush, redirect_valid, csr_we, stall}, redirect_pc);
    end
    tick();
    checks++;
    if ({mret_commit, redirect_valid} !== 2'b00) begin
      errors++; $display("FAIL mret_idle: got %b want 00", {mret_commit, redirect_valid});
    end
  endtask

  task automatic test_ecall_mret();
    int commits = 0;
    pc = 64'h2200; mtvec = 64'h9000_0002; mepc_in = 64'h4444;
    valid = 1; ecall = 1; mret = 1;
    tick();
    clear_flags();
    commits += int'(mret_commit);
    checks++;
    if (csr_we !== 1'b1 || mcause !== 64'd11 || mtval !== 64'h0 || mepc_out !== 64'h2200) begin
      errors++; $display("FAIL ecall_mret_wr: we=%b mcause=%h mtval=%h mepc=%h want 1/b/0/2200", csr_we, mcause, mtval, mepc_out);
    end
    tick();
    commits += int'(mret_commit);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 64'h9000_0000) begin
      errors++; $display("FAIL ecall_mret_jmp: rv=%b rpc=%h want 1/90000000", redirect_valid, redirect_pc);
    end
    tick();
    commits += int'(mret_commit);
    checks++;
    if (commits !== 0) begin
      errors++; $display("FAIL ecall_mret_commit: got %0d commits want 0", commits);
    end
  endtask

  task automatic test_reset_mid();
    pc = 64'h3300; mtvec = 64'h8000_0000; valid = 1; illegal = 1;
    tick();
    clear_flags();
    checks++;
    if (csr_we !== 1'b1) begin
      errors++; $display("FAIL rstmid_enter: we=%b want 1", csr_we);
    end
    rst = 1;
    tick();
    rst = 0;
    checks++;
    if ({csr_we, flush, stall, redirect_valid, mret_commit} !== 5'b0 || {mcause, mtval, mepc_out} !== '0) begin
      errors++; $display("FAIL rstmid_out: strobes=%b mcause=%h mepc=%h want 0", {csr_we, flush, stall, redirect_valid, mret_commit}, mcause, mepc_out);
    end
    tick();
    checks++;
    if ({csr_we, redirect_valid} !== 2'b00) begin
      errors++; $display("FAIL rstmid_noredir: got %b want 00", {csr_we, redirect_valid});
    end
    pc = 64'h3000; valid = 1; ecall = 1;
    tick();
    clear_flags();
    checks++;
    if (csr_we !== 1'b1 || mcause !== 64'd11 || mepc_out !== 64'h3000) begin
      errors++; $display("FAIL rstmid_new: we=%b mcause=%h mepc=%h want 1/b/3000", csr_we, mcause, mepc_out);
    end
    tick(); tick();
  endtask

  task automatic test_ignore_in_jmp();
    int wes = 0, rvs = 0;
    pc = 64'h5000; icu = 64'h5001; mtvec = 64'h8000_0000; valid = 1; load_mis = 1;
    tick();
    clear_flags();
    wes += int'(csr_we); rvs += int'(redirect_valid);
    tick();
    // Now in TRAP_JMP: present a store misaligned for this cycle only.
    wes += int'(csr_we); rvs += int'(redirect_valid);
    valid = 1; store_mis = 1; icu = 64'h6002;
    tick();
    clear_flags();
    for (int c = 0; c < 3; c++) begin
      wes += int'(csr_we); rvs += int'(redirect_valid);
      tick();
    end
    checks++;
    if (wes !== 1 || rvs !== 1) begin
      errors++; $display("FAIL ignore_jmp: csr_we=%0d redirects=%0d want 1/1", wes, rvs);
    end
    checks++;
    if (mcause !== 64'd4 || mtval !== 64'h5001) begin
      errors++; $display("FAIL ignore_jmp_latch: mcause=%h mtval=%h want 4/5001", mcause, mtval);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] we_trace = '0;
    pc = 64'h7000; valid = 1; ecall = 1;
    for (int c = 0; c < 6; c++) begin
      tick();
      we_trace[c] = csr_we;
      if (c == 2) pc = 64'h7100;
    end
    clear_flags();
    // Held ecall re-enters on the IDLE edge: writes in cycles 0 and 3.
    checks++;
    if (we_trace !== 6'b001001) begin
      errors++; $display("FAIL b2b_trace: got %b want 001001", we_trace);
    end
    checks++;
    if (mepc_out !== 64'h7100 || mcause !== 64'd11) begin
      errors++; $display("FAIL b2b_latch: mepc=%h mcause=%h want 7100/b", mepc_out, mcause);
    end
    tick(); tick();
  endtask

  task automatic test_valid_low();
    int strobes = 0;
    valid = 0; ecall = 1; mret = 1; illegal = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      strobes += int'(csr_we) + int'(redirect_valid) + int'(mret_commit) + int'(flush);
    end
    clear_flags();
    checks++;
    if (strobes !== 0) begin
      errors++; $display("FAIL valid_low: got %0d strobes want 0", strobes);
    end
  endtask

  initial begin
    test_reset();
    test_load_misaligned();
    test_priority();
    test_mret();
    test_ecall_mret();
    test_reset_mid();
    test_ignore_in_jmp();
    test_back_to_back();
    test_valid_low();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
